xor_gate: RTL and testbench
===========================

XOR_GATE -- requirements
Module: xor_gate

Interface
REQ-001: Parameter WIDTH, default 1, operand/result bit width (legal range 1..64).
REQ-002: Parameter CNT_W, default 16, width of the statistics counter.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  reset, synchronous, active-low.
REQ-005: a  input  WIDTH  operand A.
REQ-006: b  input  WIDTH  operand B.
REQ-007: in_valid  input  1  qualifies a/b for the registered path.
REQ-008: y  output  WIDTH  combinational result a XOR b.
REQ-009: y_q  output  WIDTH  registered result.
REQ-010: out_valid  output  1  y_q/parity_q hold a freshly captured result.
REQ-011: parity_q  output  1  registered XOR-reduction of the captured result.
REQ-012: diff_count  output  CNT_W  saturating count of differing bit positions (present only with XOR_GATE_STATS_EN).

Function
REQ-013: y SHALL equal a XOR b bitwise at all times, independent of clk, rst_n and in_valid, with zero-cycle latency.
REQ-014: For WIDTH=1, y SHALL follow the truth table 00->0, 01->1, 10->1, 11->0.
REQ-015: On a rising clk edge with rst_n=1 and in_valid=1, y_q SHALL load a XOR b and parity_q SHALL load the XOR-reduction of (a XOR b); latency one cycle.
REQ-016: With in_valid=0 at the edge, y_q and parity_q SHALL hold their previous values.
REQ-017: out_valid SHALL be the in_valid registered one cycle (1 in the cycle after a capture, 0 otherwise).
REQ-018: X/Z on a or b SHALL NOT be masked; no internal defaulting of undriven inputs.
REQ-019: No handshake back-pressure; every in_valid=1 cycle is accepted.

Reset
REQ-020: When rst_n=0 at a rising clk edge: y_q=0, parity_q=0, out_valid=0, diff_count=0.
REQ-021: Reset SHALL take precedence over in_valid in the same cycle; the operand pair presented during reset is discarded.
REQ-022: Reset SHALL NOT affect the combinational output y.
REQ-023: Reset asserted mid-stream SHALL clear state at the next edge; capture resumes on the first edge with rst_n=1 and in_valid=1.

Configuration
REQ-024: Macro XOR_GATE_STATS_EN, when defined, SHALL compile in diff_count and its logic.
REQ-025: With XOR_GATE_STATS_EN: on each capture, diff_count SHALL add popcount(a XOR b), saturating at 2^CNT_W-1 (never wraps); unchanged when in_valid=0.
REQ-026: Without XOR_GATE_STATS_EN: diff_count port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-027: WIDTH=1, apply (0,0),(0,1),(1,0),(1,1) with 10-unit gaps, no clock -> y=0,1,1,0.
REQ-028: WIDTH=8, rst_n=0 one edge then 1, in_valid=1, a=8'hF0, b=8'h3C -> next cycle y_q=8'hCC, parity_q=0, out_valid=1.
REQ-029: After capture of 8'h01^8'h00, drop in_valid for 3 cycles -> y_q stays 8'h01, parity_q=1, out_valid=0.
REQ-030: rst_n=0 and in_valid=1 same edge with a=8'hFF, b=8'h00 -> y_q=0, out_valid=0, y=8'hFF combinationally.
REQ-031: XOR_GATE_STATS_EN, CNT_W=4, WIDTH=8, capture a=8'hFF, b=8'h00 twice -> diff_count=8 then 15 (saturated); third capture keeps 15.
REQ-032: Random a/b for 1000 cycles with random in_valid -> y and y_q/parity_q match a reference model every cycle.

Source files
------------

// File: rtl/xor_gate.sv
// Bitwise XOR with a combinational result plus a registered result, parity and valid flag.
// Define XOR_GATE_STATS_EN to add diff_count, a saturating count of differing bit positions.
module xor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             parity_q
`ifdef XOR_GATE_STATS_EN
    ,
    output logic [CNT_W-1:0] diff_count
`endif
);

    logic [WIDTH-1:0] diff_bits;
    logic [WIDTH-1:0] y_q_reg;
    logic             parity_reg;
    logic             valid_reg;

    // Plain per-bit XOR so X/Z on either operand propagates untouched.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_xor
            assign diff_bits[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    assign y         = diff_bits;
    assign y_q       = y_q_reg;
    assign parity_q  = parity_reg;
    assign out_valid = valid_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q_reg    <= '0;
            parity_reg <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                y_q_reg    <= diff_bits;
                parity_reg <= ^diff_bits;
            end
        end
    end

`ifdef XOR_GATE_STATS_EN
    localparam int POP_W = $clog2(WIDTH + 1);
    // One spare bit above the wider operand so the sum can never overflow before the clamp.
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [POP_W-1:0] pop_count;
    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        pop_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_count = pop_count + POP_W'(diff_bits[i]);
        end
    end

    always_comb begin
        cnt_sum  = SUM_W'(cnt_reg) + SUM_W'(pop_count);
        cnt_next = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (in_valid) begin
            cnt_reg <= cnt_next;
        end
    end

    assign diff_count = cnt_reg;
`endif

endmodule

// File: tb/tb_xor_gate.sv
// Self-checking bench for xor_gate: directed scenarios plus randomized traffic against
// a behavioural model built from popcounts and min() rather than from the register logic.
module tb_xor_gate;
    localparam int W  = 8;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b, y, y_q;
    logic         in_valid, out_valid, parity_q;
    logic         a1, b1, y1, y_q1, out_valid1, parity_q1;
`ifdef XOR_GATE_STATS_EN
    logic [CW-1:0] diff_count;
    logic [15:0]   diff_count1;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [W-1:0] m_yq;
    logic         m_par;
    logic         m_valid;
    int           m_cnt;

    always #5 clk = ~clk;

    xor_gate #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
        .y(y), .y_q(y_q), .out_valid(out_valid), .parity_q(parity_q)
`ifdef XOR_GATE_STATS_EN
        , .diff_count(diff_count)
`endif
    );

    xor_gate #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(1'b0),
        .y(y1), .y_q(y_q1), .out_valid(out_valid1), .parity_q(parity_q1)
`ifdef XOR_GATE_STATS_EN
        , .diff_count(diff_count1)
`endif
    );

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        int ones;
        ones = $countones(a ^ b);
        if (!rst_n) begin
            m_yq = '0; m_par = 1'b0; m_valid = 1'b0; m_cnt = 0;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                m_yq  = a ^ b;
                m_par = (ones % 2) == 1;
                m_cnt = (m_cnt + ones > CNT_MAX) ? CNT_MAX : m_cnt + ones;
            end
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] pat;
        logic       exp;
        for (int i = 0; i < 4; i++) begin
            pat = 2'(i);
            a1 = pat[1]; b1 = pat[0];
            #10;
            exp = (i == 1 || i == 2);
            n_vec++;
            $display("truth a=%b b=%b y=%b", a1, b1, y1);
            if (y1 !== exp) begin
                n_err++;
                $display("FAIL truth_table a=%b b=%b: got y=%b expected %b", a1, b1, y1, exp);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; a = 8'h5A; b = 8'h00;
        @(negedge clk);
        @(negedge clk);
        $display("reset y_q=%h parity_q=%b out_valid=%b", y_q, parity_q, out_valid);
        n_vec++; if (y_q !== 8'h00) begin n_err++; $display("FAIL reset_y_q got %h expected 00", y_q); end
        n_vec++; if (parity_q !== 1'b0) begin n_err++; $display("FAIL reset_parity got %b expected 0", parity_q); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
`ifdef XOR_GATE_STATS_EN
        n_vec++; if (diff_count !== '0) begin n_err++; $display("FAIL reset_diff_count got %0d expected 0", diff_count); end
`endif
    endtask

    task automatic test_capture();
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; a = 8'hF0; b = 8'h3C;
        @(negedge clk);
        $display("capture F0^3C y_q=%h parity_q=%b out_valid=%b", y_q, parity_q, out_valid);
        n_vec++; if (y_q !== 8'hCC) begin n_err++; $display("FAIL capture_y_q got %h expected CC", y_q); end
        n_vec++; if (parity_q !== 1'b0) begin n_err++; $display("FAIL capture_parity got %b expected 0", parity_q); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL capture_out_valid got %b expected 1", out_valid); end
    endtask

    task automatic test_hold();
        a = 8'h01; b = 8'h00; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = 8'hA7; b = 8'h13;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            $display("hold cycle %0d y_q=%h parity_q=%b out_valid=%b", i, y_q, parity_q, out_valid);
            n_vec++; if (y_q !== 8'h01) begin n_err++; $display("FAIL hold_y_q got %h expected 01", y_q); end
            n_vec++; if (parity_q !== 1'b1) begin n_err++; $display("FAIL hold_parity got %b expected 1", parity_q); end
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_out_valid got %b expected 0", out_valid); end
        end
    endtask

    task automatic test_reset_priority();
        rst_n = 1'b0; in_valid = 1'b1; a = 8'hFF; b = 8'h00;
        #1;
        n_vec++; if (y !== 8'hFF) begin n_err++; $display("FAIL rst_prio_comb_y got %h expected FF", y); end
        @(negedge clk);
        $display("reset_priority y=%h y_q=%h out_valid=%b", y, y_q, out_valid);
        n_vec++; if (y_q !== 8'h00) begin n_err++; $display("FAIL rst_prio_y_q got %h expected 00", y_q); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_prio_out_valid got %b expected 0", out_valid); end
        n_vec++; if (parity_q !== 1'b0) begin n_err++; $display("FAIL rst_prio_parity got %b expected 0", parity_q); end
        n_vec++; if (y !== 8'hFF) begin n_err++; $display("FAIL rst_prio_y_in_reset got %h expected FF", y); end
    endtask

`ifdef XOR_GATE_STATS_EN
    task automatic test_stats_saturation();
        int exp_cnt [3] = '{8, 15, 15};
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            $display("stats capture %0d diff_count=%0d", i, diff_count);
            n_vec++;
            if (diff_count !== CW'(exp_cnt[i])) begin
                n_err++;
                $display("FAIL stats_capture_%0d got %0d expected %0d", i, diff_count, exp_cnt[i]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (diff_count !== 4'd15) begin n_err++; $display("FAIL stats_idle_hold got %0d expected 15", diff_count); end
    endtask
`endif

    task automatic test_random();
        rst_n = 1'b0; in_valid = 1'b0;
        model_edge();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            $display("rand %0d y_q=%h parity_q=%b out_valid=%b", i, y_q, parity_q, out_valid);
            n_vec++; if (y_q !== m_yq) begin n_err++; $display("FAIL rand_y_q cycle %0d got %h expected %h", i, y_q, m_yq); end
            n_vec++; if (parity_q !== m_par) begin n_err++; $display("FAIL rand_parity cycle %0d got %b expected %b", i, parity_q, m_par); end
            n_vec++; if (out_valid !== m_valid) begin n_err++; $display("FAIL rand_out_valid cycle %0d got %b expected %b", i, out_valid, m_valid); end
`ifdef XOR_GATE_STATS_EN
            n_vec++; if (diff_count !== CW'(m_cnt)) begin n_err++; $display("FAIL rand_diff_count cycle %0d got %0d expected %0d", i, diff_count, m_cnt); end
`endif
            rst_n    = ($urandom_range(0, 39) != 0);
            in_valid = $urandom_range(0, 1) == 1;
            a        = W'($urandom);
            b        = W'($urandom);
            model_edge();
            #1;
            n_vec++; if (y !== (a ^ b)) begin n_err++; $display("FAIL rand_y cycle %0d got %h expected %h", i, y, a ^ b); end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; a1 = 1'b0; b1 = 1'b0;
        test_truth_table();
        test_reset();
        test_capture();
        test_hold();
        test_reset_priority();
`ifdef XOR_GATE_STATS_EN
        test_stats_saturation();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
